id_ex_control: RTL and testbench

Main-control decoder and ID/EX control pipeline register: the producing end of the ALUOp/funct interface consumed by the EX-stage ALU control decoder. It decodes the ID-stage instruction into datapath control signals and ALUOp, and registers them with the register fields and extended immediate into the ID/EX stage. Stall/flush handling is built in, and a bubble counter supports performance checks. It sits between the IF/ID register and the EX stage.

---
 rtl/id_ex_control.sv | 172 +++++++++++++++++
 tb/tb_id_ex_control.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_control.sv
// Main-control decoder for the 32-bit MIPS subset plus the ID/EX control pipeline register.
// Handles flush/hold and keeps a saturating count of bubbles loaded into ID/EX.
module id_ex_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_instr,
    input  logic        id_valid,
    input  logic        flush,
    input  logic        hold,
    output logic        id_jump,
    output logic        id_illegal,
    output logic        ex_valid,
    output logic [1:0]  ex_ALUOp,
    output logic [5:0]  ex_funct,
    output logic        ex_RegDst,
    output logic        ex_ALUSrc,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_MemtoReg,
    output logic        ex_RegWrite,
    output logic        ex_Branch,
    output logic        ex_BranchNe,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_imm,
    output logic        ex_illegal,
    output logic [15:0] bubble_count
);

    typedef struct packed {
        logic        valid;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        regdst;
        logic        alusrc;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        regwrite;
        logic        branch;
        logic        branchne;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [5:0] opcode;
    logic       unsupported;
    logic       is_nop;
    logic       to_bubble;
    ctrl_t      dec;
    ctrl_t      nxt;
    ctrl_t      q;

    assign opcode = id_instr[31:26];
    assign is_nop = (id_instr == 32'h0000_0000);

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec         = '0;
        unsupported = 1'b0;
        dec.valid   = 1'b1;
        dec.rs      = id_instr[25:21];
        dec.rt      = id_instr[20:16];
        dec.rd      = id_instr[15:11];
        dec.imm     = {{16{id_instr[15]}}, id_instr[15:0]};
        case (opcode)
            OP_RTYPE: begin
                dec.regdst   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b10;
                dec.funct    = id_instr[5:0];
                case (id_instr[5:0])
                    6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: ;
                    default: unsupported = 1'b1;
                endcase
            end
            OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec.branch = 1'b1;
                dec.aluop  = 2'b01;
            end
            OP_BNE: begin
                dec.branch   = 1'b1;
                dec.branchne = 1'b1;
                dec.aluop    = 2'b01;
            end
            OP_ADDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
            end
            OP_ANDI: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.aluop    = 2'b11;
                dec.imm      = {16'h0000, id_instr[15:0]};
            end
            OP_J: ;
            default: unsupported = 1'b1;
        endcase
    end

    // The nop decodes as R-type funct 0 but is a deliberate bubble, not an illegal instruction.
    assign id_illegal = id_valid && unsupported && !is_nop;
    assign id_jump    = id_valid && (opcode == OP_J);
    assign to_bubble  = !id_valid || is_nop || unsupported;

    always_comb begin
        nxt = dec;
        if (to_bubble) begin
            nxt         = '0;
            nxt.illegal = id_illegal;
        end
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q            <= '0;
            bubble_count <= '0;
        end else if (flush) begin
            q            <= '0;
            bubble_count <= sat_inc(bubble_count);
        end else if (!hold) begin
            q <= nxt;
            if (to_bubble) bubble_count <= sat_inc(bubble_count);
        end
    end

    assign ex_valid    = q.valid;
    assign ex_ALUOp    = q.aluop;
    assign ex_funct    = q.funct;
    assign ex_RegDst   = q.regdst;
    assign ex_ALUSrc   = q.alusrc;
    assign ex_MemRead  = q.memread;
    assign ex_MemWrite = q.memwrite;
    assign ex_MemtoReg = q.memtoreg;
    assign ex_RegWrite = q.regwrite;
    assign ex_Branch   = q.branch;
    assign ex_BranchNe = q.branchne;
    assign ex_rs       = q.rs;
    assign ex_rt       = q.rt;
    assign ex_rd       = q.rd;
    assign ex_imm      = q.imm;
    assign ex_illegal  = q.illegal;

endmodule

// File: tb/tb_id_ex_control.sv
// Directed self-checking bench for id_ex_control: decode, illegal/nop, hold/flush, jump, saturation.
module tb_id_ex_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        flush;
    logic        hold;
    logic        id_jump;
    logic        id_illegal;
    logic        ex_valid;
    logic [1:0]  ex_ALUOp;
    logic [5:0]  ex_funct;
    logic        ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite;
    logic        ex_MemtoReg, ex_RegWrite, ex_Branch, ex_BranchNe;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_imm;
    logic        ex_illegal;
    logic [15:0] bubble_count;

    int checks = 0;
    int errors = 0;

    id_ex_control dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid),
        .flush(flush), .hold(hold), .id_jump(id_jump), .id_illegal(id_illegal),
        .ex_valid(ex_valid), .ex_ALUOp(ex_ALUOp), .ex_funct(ex_funct),
        .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
        .ex_Branch(ex_Branch), .ex_BranchNe(ex_BranchNe), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_illegal(ex_illegal), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    // Control bits in a fixed order: RegDst ALUSrc MemRead MemWrite MemtoReg RegWrite Branch BranchNe
    wire [7:0] ctl = {ex_RegDst, ex_ALUSrc, ex_MemRead, ex_MemWrite,
                      ex_MemtoReg, ex_RegWrite, ex_Branch, ex_BranchNe};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; id_instr = 32'h0; id_valid = 1'b0; flush = 1'b0; hold = 1'b0;

        // Reset, then add $3,$1,$2
        tick();
        check("reset_ctl", {ex_valid, ex_ALUOp, ex_funct, ctl, ex_illegal}, 0);
        check("reset_regs", {ex_rs, ex_rt, ex_rd, ex_imm}, 0);
        check("reset_cnt", bubble_count, 0);
        id_instr = 32'h0022_1820; id_valid = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("add_ctl", {ex_valid, ex_ALUOp, ex_funct, ctl}, {1'b1, 2'b10, 6'h20, 8'b1000_0100});
        check("add_regs", {ex_rs, ex_rt, ex_rd}, {5'd1, 5'd2, 5'd3});
        check("add_cnt", bubble_count, 0);

        // lw $2,-4($1)
        id_instr = 32'h8C22_FFFC;
        tick();
        check("lw_ctl", {ex_valid, ex_ALUOp, ex_funct, ctl}, {1'b1, 2'b00, 6'h00, 8'b0110_1100});
        check("lw_imm", ex_imm, 32'hFFFF_FFFC);

        // bne
        id_instr = 32'h1422_FFFE;
        tick();
        check("bne_ctl", {ex_valid, ex_ALUOp, ctl}, {1'b1, 2'b01, 8'b0000_0011});
        check("bne_imm", ex_imm, 32'hFFFF_FFFE);

        // andi $2,$1,0x8000 zero-extends
        id_instr = 32'h3022_8000;
        tick();
        check("andi_ctl", {ex_valid, ex_ALUOp, ctl}, {1'b1, 2'b11, 8'b0100_0100});
        check("andi_imm", ex_imm, 32'h0000_8000);

        // nor (unsupported funct)
        id_instr = 32'h0022_1827;
        #1 check("nor_id_illegal", id_illegal, 1);
        tick();
        check("nor_ex", {ex_illegal, ex_valid, ctl, ex_ALUOp}, {1'b1, 1'b0, 8'h00, 2'b00});

        // ori (unsupported opcode)
        id_instr = 32'h3422_0001;
        #1 check("ori_id_illegal", id_illegal, 1);
        tick();
        check("ori_ex", {ex_illegal, ex_valid, ex_imm}, {1'b1, 1'b0, 32'h0});

        // nop
        id_instr = 32'h0000_0000;
        #1 check("nop_id_illegal", id_illegal, 0);
        tick();
        check("nop_ex", {ex_illegal, ex_valid, ex_funct}, 0);
        check("bubbles_3", bubble_count, 3);

        // Hold for 3 edges while the instruction changes
        id_instr = 32'h0022_1820;
        tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_instr = (i == 1) ? 32'h8C22_FFFC : 32'h1422_FFFE;
            tick();
            check("hold_ctl", {ex_valid, ex_ALUOp, ex_funct, ctl, ex_rd}, {1'b1, 2'b10, 6'h20, 8'b1000_0100, 5'd3});
            check("hold_cnt", bubble_count, 3);
        end
        flush = 1'b1;
        tick();
        check("flush_ex", {ex_valid, ex_ALUOp, ex_funct, ctl, ex_illegal, ex_imm}, 0);
        check("flush_cnt", bubble_count, 4);
        flush = 1'b0; hold = 1'b0;

        // Next non-hold edge loads the current instruction
        id_instr = 32'h8C22_FFFC;
        tick();
        check("post_hold_lw", {ex_valid, ctl}, {1'b1, 8'b0110_1100});

        // Jump
        id_instr = 32'h0800_0010;
        #1 check("j_id_jump", {id_jump, id_illegal}, 2'b10);
        tick();
        check("j_ex", {ex_valid, ex_ALUOp, ctl, ex_illegal}, {1'b1, 2'b00, 8'h00, 1'b0});
        check("j_cnt", bubble_count, 4);
        id_valid = 1'b0;
        #1 check("j_invalid_id_jump", id_jump, 0);
        tick();
        check("j_invalid_ex", {ex_valid, ex_illegal}, 0);
        check("j_invalid_cnt", bubble_count, 5);

        // Saturation: 5 -> 0xFFFE after 65529 bubbles
        for (int i = 0; i < 65529; i++) tick();
        check("sat_fffe", bubble_count, 16'hFFFE);
        tick();
        check("sat_ffff", bubble_count, 16'hFFFF);
        for (int i = 0; i < 10; i++) tick();
        check("sat_hold", bubble_count, 16'hFFFF);

        // Reset mid-stream wins over flush/hold
        id_valid = 1'b1; id_instr = 32'h0022_1820;
        tick();
        rst = 1'b1; flush = 1'b1; hold = 1'b1;
        tick();
        check("rst_mid_cnt", bubble_count, 0);
        check("rst_mid_ctl", {ex_valid, ex_ALUOp, ex_funct, ctl, ex_rd}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
